// File: rtl/pipes.sv
// Shared pipeline package: stage payload structs, stage handshake wiring and
// the default elastic-buffer depth used between adjacent stages.
// Contents: u1, handshake_t, fetch_data_t, decode_data_t, PIPE_BUF_DEPTH, ptr_w().
package pipes;

   typedef logic u1;

   // Per-stage valid/ready pair for wiring stage boundaries.
   typedef struct packed {
      u1 valid;
      u1 ready;
   } handshake_t;

   // Stage payloads; a pipe_stage_buf carries them flattened via $bits().
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fetch_data_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [31:0] imm;
   } decode_data_t;

   localparam int PIPE_BUF_DEPTH = 2;

   // Pointer width for a DEPTH-entry ring; a single entry still needs one bit.
   function automatic int ptr_w(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/pipe_stage_buf_ptr.sv
// Wrap-around ring pointer for pipe_stage_buf: counts 0..DEPTH-1 then back to 0.
// Latency: new value visible the cycle after inc/clr. No backpressure of its own.
// Ports: clk, reset (sync, active-low), clr (return to 0), inc (advance), ptr (current value).
module pipe_stage_buf_ptr
   import pipes::*;
#(
   parameter int DEPTH = PIPE_BUF_DEPTH
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    clr,
   input  logic                    inc,
   output logic [ptr_w(DEPTH)-1:0] ptr
);

   localparam int PW = ptr_w(DEPTH);

   // Explicit compare keeps non-power-of-two depths on a proper ring.
   always_ff @(posedge clk) begin
      if (!reset) begin
         ptr <= '0;
      end else if (clr) begin
         ptr <= '0;
      end else if (inc) begin
         if (ptr == PW'(DEPTH - 1)) begin
            ptr <= '0;
         end else begin
            ptr <= ptr + PW'(1);
         end
      end
   end

endmodule

// File: rtl/pipe_stage_buf.sv
// Elastic DEPTH-entry stage buffer with valid/ready on both sides and flush.
// Latency: one cycle push-to-head, no bypass. in_ready depends only on count,
// so a full buffer refuses a push even while its head is being popped.
// Ports: clk, reset (sync, active-low), flush, in_valid/in_ready/in_data,
//        out_valid/out_ready/out_data, count (occupancy).
module pipe_stage_buf
   import pipes::*;
#(
   parameter int WIDTH = 64,
   parameter int DEPTH = PIPE_BUF_DEPTH
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       flush,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [WIDTH-1:0]           in_data,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [WIDTH-1:0]           out_data,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int PW = ptr_w(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    rd_ptr;
   logic [PW-1:0]    wr_ptr;
   logic             push;
   logic             pop;

   assign in_ready  = (count != CW'(DEPTH));
   assign out_valid = (count != '0);
   assign out_data  = mem[rd_ptr];

   // A push in the flush cycle is dropped. A pop in that cycle still counts
   // downstream, but the pointer clear below overrides its rd_ptr advance.
   assign push = in_valid && in_ready && !flush;
   assign pop  = out_valid && out_ready;

   pipe_stage_buf_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
      .clk   (clk),
      .reset (reset),
      .clr   (flush),
      .inc   (push),
      .ptr   (wr_ptr)
   );

   pipe_stage_buf_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
      .clk   (clk),
      .reset (reset),
      .clr   (flush),
      .inc   (pop),
      .ptr   (rd_ptr)
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         count <= '0;
      end else if (flush) begin
         count <= '0;
      end else if (push && !pop) begin
         count <= count + CW'(1);
      end else if (!push && pop) begin
         count <= count - CW'(1);
      end
   end

   // Payload storage is never cleared; occupancy alone decides what is valid.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= in_data;
      end
   end

endmodule

// File: tb/tb_pipe_stage_buf.sv
module tb_pipe_stage_buf;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;

   // DEPTH=2 instance
   logic       d2_fl, d2_iv, d2_ir, d2_ov, d2_or;
   logic [7:0] d2_id, d2_od;
   logic [1:0] d2_cnt;
   // DEPTH=3 instance
   logic       d3_fl, d3_iv, d3_ir, d3_ov, d3_or;
   logic [7:0] d3_id, d3_od;
   logic [1:0] d3_cnt;

   pipe_stage_buf #(.WIDTH(8), .DEPTH(2)) u_d2 (
      .clk(clk), .reset(rst), .flush(d2_fl),
      .in_valid(d2_iv), .in_ready(d2_ir), .in_data(d2_id),
      .out_valid(d2_ov), .out_ready(d2_or), .out_data(d2_od), .count(d2_cnt)
   );

   pipe_stage_buf #(.WIDTH(8), .DEPTH(3)) u_d3 (
      .clk(clk), .reset(rst), .flush(d3_fl),
      .in_valid(d3_iv), .in_ready(d3_ir), .in_data(d3_id),
      .out_valid(d3_ov), .out_ready(d3_or), .out_data(d3_od), .count(d3_cnt)
   );

   int n_vec = 0;
   int n_err = 0;
   bit chk_en = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Scoreboards: queues hold the payloads the buffer must still deliver.
   // Occupancy/flags are checked against queue size, pops against the head.
   logic [7:0] q2[$];
   logic [7:0] q3[$];
   int  d3_pops = 0;
   int  s2, s3;
   bit  p2_push, p2_pop, p3_push, p3_pop;

   always @(negedge clk) begin
      if (chk_en) begin
         s2 = q2.size();
         chk("d2_count", 32'(d2_cnt), 32'(s2));
         chk("d2_out_valid", 32'(d2_ov), 32'(s2 != 0));
         chk("d2_in_ready", 32'(d2_ir), 32'(s2 != 2));
         if (!rst) begin
            q2.delete();
         end else begin
            p2_pop  = (s2 != 0) && d2_or;
            p2_push = d2_iv && (s2 != 2) && !d2_fl;
            if (p2_pop) begin
               chk("d2_pop_data", 32'(d2_od), 32'(q2[0]));
               void'(q2.pop_front());
            end
            if (d2_fl) q2.delete();
            else if (p2_push) q2.push_back(d2_id);
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         s3 = q3.size();
         chk("d3_count", 32'(d3_cnt), 32'(s3));
         chk("d3_out_valid", 32'(d3_ov), 32'(s3 != 0));
         chk("d3_in_ready", 32'(d3_ir), 32'(s3 != 3));
         if (!rst) begin
            q3.delete();
         end else begin
            p3_pop  = (s3 != 0) && d3_or;
            p3_push = d3_iv && (s3 != 3) && !d3_fl;
            if (p3_pop) begin
               chk("d3_pop_data", 32'(d3_od), 32'(q3[0]));
               void'(q3.pop_front());
               d3_pops++;
            end
            if (d3_fl) q3.delete();
            else if (p3_push) q3.push_back(d3_id);
         end
      end
   end

   // Vector = inputs for one cycle plus the outputs expected during that
   // cycle (i.e. the state produced by all earlier vectors).
   typedef struct {
      logic       rst, fl, iv;
      logic [7:0] dat;
      logic       ordy;
      int         cnt;
      logic       ov, ir;
      logic [7:0] od;
   } vec_t;

   vec_t vt[27];

   initial begin
      int idx, start;
      rst = 1'b0;
      d2_fl = 0; d2_iv = 0; d2_id = 0; d2_or = 0;
      d3_fl = 0; d3_iv = 0; d3_id = 0; d3_or = 0;

      //          rst fl iv  dat   or  cnt ov ir  od
      vt[0]  = '{0, 0, 1, 8'h55, 0,  0, 0, 1, 8'h00};  // reset held, push ignored
      vt[1]  = '{0, 0, 1, 8'h55, 0,  0, 0, 1, 8'h00};
      vt[2]  = '{1, 0, 1, 8'h11, 1,  0, 0, 1, 8'h00};  // stream
      vt[3]  = '{1, 0, 1, 8'h22, 1,  1, 1, 1, 8'h11};
      vt[4]  = '{1, 0, 1, 8'h33, 1,  1, 1, 1, 8'h22};
      vt[5]  = '{1, 0, 0, 8'h00, 0,  1, 1, 1, 8'h33};
      vt[6]  = '{1, 0, 0, 8'h00, 1,  1, 1, 1, 8'h33};
      vt[7]  = '{1, 0, 1, 8'h0A, 0,  0, 0, 1, 8'h00};  // stall / full
      vt[8]  = '{1, 0, 1, 8'h0B, 0,  1, 1, 1, 8'h0A};
      vt[9]  = '{1, 0, 1, 8'h0C, 0,  2, 1, 0, 8'h0A};
      vt[10] = '{1, 0, 1, 8'h0C, 0,  2, 1, 0, 8'h0A};
      vt[11] = '{1, 0, 1, 8'h0C, 1,  2, 1, 0, 8'h0A};  // full: pop only
      vt[12] = '{1, 0, 1, 8'h0C, 1,  1, 1, 1, 8'h0B};
      vt[13] = '{1, 0, 0, 8'h00, 1,  1, 1, 1, 8'h0C};
      vt[14] = '{1, 0, 1, 8'hD1, 0,  0, 0, 1, 8'h00};
      vt[15] = '{1, 0, 1, 8'hD2, 0,  1, 1, 1, 8'hD1};
      vt[16] = '{1, 1, 1, 8'h0F, 0,  2, 1, 0, 8'hD1};  // flush when full
      vt[17] = '{1, 0, 0, 8'h00, 1,  0, 0, 1, 8'h00};
      vt[18] = '{1, 0, 1, 8'hE1, 0,  0, 0, 1, 8'h00};
      vt[19] = '{1, 1, 1, 8'h0F, 0,  1, 1, 1, 8'hE1};  // flush drops legal push
      vt[20] = '{1, 0, 0, 8'h00, 0,  0, 0, 1, 8'h00};
      vt[21] = '{1, 0, 1, 8'h77, 0,  0, 0, 1, 8'h00};
      vt[22] = '{0, 0, 1, 8'h88, 0,  1, 1, 1, 8'h77};  // reset mid-stream + push
      vt[23] = '{1, 0, 0, 8'h00, 0,  0, 0, 1, 8'h00};
      vt[24] = '{1, 0, 1, 8'h99, 1,  0, 0, 1, 8'h00};
      vt[25] = '{1, 1, 0, 8'h00, 1,  1, 1, 1, 8'h99};  // flush with same-cycle pop
      vt[26] = '{1, 0, 0, 8'h00, 0,  0, 0, 1, 8'h00};

      @(posedge clk);
      chk_en = 1'b1;
      for (int i = 0; i < 27; i++) begin
         #1;
         rst = vt[i].rst; d2_fl = vt[i].fl; d2_iv = vt[i].iv;
         d2_id = vt[i].dat; d2_or = vt[i].ordy;
         @(negedge clk);
         chk($sformatf("v%0d_count", i), 32'(d2_cnt), 32'(vt[i].cnt));
         chk($sformatf("v%0d_out_valid", i), 32'(d2_ov), 32'(vt[i].ov));
         chk($sformatf("v%0d_in_ready", i), 32'(d2_ir), 32'(vt[i].ir));
         if (vt[i].ov) chk($sformatf("v%0d_out_data", i), 32'(d2_od), 32'(vt[i].od));
         @(posedge clk);
      end
      #1;
      d2_iv = 0; d2_or = 0; d2_fl = 0;

      // DEPTH=3 wrap: 7 items, random out_ready; order checked by scoreboard.
      idx = 0;
      start = d3_pops;
      for (int c = 0; c < 400 && (d3_pops - start) < 7; c++) begin
         @(posedge clk); #1;
         d3_iv = (idx < 7);
         d3_id = 8'(8'h30 + idx);
         d3_or = 1'($urandom_range(0, 1));
         @(negedge clk);
         if (d3_iv && d3_ir) idx++;
      end
      @(posedge clk); #1;
      d3_iv = 0; d3_or = 0;
      @(negedge clk);
      chk("d3_wrap_items", 32'(d3_pops - start), 32'd7);

      // DEPTH=3 stall: continuous pushes fill it in three cycles.
      for (int k = 0; k < 5; k++) begin
         @(posedge clk); #1;
         d3_iv = 1; d3_id = 8'(8'hC0 + (k < 3 ? k : 3)); d3_or = 0;
      end
      @(negedge clk);
      chk("d3_full_count", 32'(d3_cnt), 32'd3);
      chk("d3_full_in_ready", 32'(d3_ir), 32'd0);
      @(posedge clk); #1;
      d3_iv = 0; d3_or = 1;
      for (int c = 0; c < 20 && d3_cnt != 0; c++) @(posedge clk);
      #1;
      chk("d3_drained", 32'(d3_cnt), 32'd0);

      // DEPTH=3 full-rate stream with continuous out_ready.
      for (int k = 0; k < 6; k++) begin
         @(posedge clk); #1;
         d3_iv = 1; d3_id = 8'(8'hD0 + k); d3_or = 1;
      end
      @(negedge clk);
      chk("d3_stream_count", 32'(d3_cnt), 32'd1);
      @(posedge clk); #1;
      d3_iv = 0;
      repeat (3) @(posedge clk);
      #1;
      chk("d3_stream_empty", 32'(d3_ov), 32'd0);

      @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

endmodule
